// File: rtl/dm_ctrl.sv
// dm_ctrl: sequences one byte/half/word load or store at a time against the
// dm_4k data memory. Sub-word stores are read-modify-write; loads are lane
// selected and sign/zero extended; misaligned or reserved-size requests
// complete with rsp_err and never reach memory.
module dm_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wbuf;

    // Half must be 2-byte aligned, word 4-byte aligned; size 11 is never legal.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Pick the little-endian lane out of a memory word and extend it.
    function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Drop the right-justified store data into its lane of the old word.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // State register; reset returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: errors skip memory, word stores skip the read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned(req_size, req_addr[1:0]))  state_nxt = RESP;
                    else if (!req_we || req_size != 2'b10)    state_nxt = RD;
                    else                                      state_nxt = WR;
                end
            end
            RD:      state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, RMW merge buffer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wbuf      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (req_we && req_size == 2'b10) wbuf <= req_wdata;
            end
            if (state == RD && we_q) wbuf <= merge_lane(dm_dout, wdata_q, size_q, addr_q[1:0]);
            // Response fields only change on the way into RESP.
            if (state_nxt == RESP) begin
                rsp_err   <= (state == IDLE);
                rsp_rdata <= (state == RD && !we_q) ?
                             load_lane(dm_dout, size_q, addr_q[1:0], sgn_q) : 32'h0;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign dm_we     = (state == WR);
    assign dm_addr   = addr_q[ADDR_W-1:2];
    assign dm_din    = wbuf;

endmodule
